// File: rtl/ro_buffer.sv
// ro_buffer: reorder buffer for the out-of-order core.
//
// A circular queue of in-flight instructions. The issuer allocates entries in
// program order. The common data bus completes them in any order. Entries
// retire in order, one per cycle at most, into the register file. A retiring
// mispredicted branch raises a one-cycle flush pulse. That pulse empties the
// whole buffer and redirects the fetcher. Entry IDs run 1..ROB_SIZE, and ID 0
// means "no entry / value ready".
//
// Ports
//   clk, rst                     clock; synchronous active-high reset
//   rdy                          global enable (low: freeze, no commit shown)
//   valid/rd/pc_from_issuer      allocation request
//   dest_to_issuer               ID the next allocation receives (tail)
//   full_to_issuer               no free entry
//   qj/qk_from_issuer            operand tags to probe
//   ready/value_j/k_to_issuer    probe results (combinational, CDB forwarded)
//   *_from_cdb                   result broadcast (+ mispredict flag)
//   dest/rd/value_to_reg_file    registered commit port (dest 0 = none)
//   reset_to_rob_bus             one-cycle pipeline flush pulse
//   pc_to_fetcher                redirect PC, valid with the flush pulse
module ro_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int ID_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                valid_from_issuer,
  input  logic [4:0]          rd_from_issuer,
  input  logic [31:0]         pc_from_issuer,
  output logic [ID_WIDTH-1:0] dest_to_issuer,
  output logic                full_to_issuer,
  input  logic [ID_WIDTH-1:0] qj_from_issuer,
  input  logic [ID_WIDTH-1:0] qk_from_issuer,
  output logic                ready_j_to_issuer,
  output logic                ready_k_to_issuer,
  output logic [31:0]         value_j_to_issuer,
  output logic [31:0]         value_k_to_issuer,
  input  logic                valid_from_cdb,
  input  logic [ID_WIDTH-1:0] dest_from_cdb,
  input  logic [31:0]         value_from_cdb,
  input  logic                mispredict_from_cdb,
  output logic [ID_WIDTH-1:0] dest_to_reg_file,
  output logic [4:0]          rd_to_reg_file,
  output logic [31:0]         value_to_reg_file,
  output logic                reset_to_rob_bus,
  output logic [31:0]         pc_to_fetcher
);

  localparam int CNT_W = $clog2(ROB_SIZE + 1);
  localparam logic [ID_WIDTH-1:0] ID_FIRST = ID_WIDTH'(1);
  localparam logic [ID_WIDTH-1:0] ID_LAST  = ID_WIDTH'(ROB_SIZE);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(ROB_SIZE);

  // Slot 0 exists only so any ID_WIDTH-bit tag indexes the arrays. It is
  // never allocated, so its busy bit stays 0.
  logic        r_busy  [0:ROB_SIZE];
  logic        r_ready [0:ROB_SIZE];
  logic        r_misp  [0:ROB_SIZE];
  logic [4:0]  r_rd    [0:ROB_SIZE];
  logic [31:0] r_value [0:ROB_SIZE];
  logic [31:0] r_pc    [0:ROB_SIZE];

  logic [ID_WIDTH-1:0] r_head;
  logic [ID_WIDTH-1:0] r_tail;
  logic [CNT_W-1:0]    r_count;

  logic                r_flush;
  logic [ID_WIDTH-1:0] r_dest_out;
  logic [4:0]          r_rd_out;
  logic [31:0]         r_value_out;
  logic [31:0]         r_pc_out;

  logic w_active;
  logic w_full;
  logic w_alloc;
  logic w_commit;
  logic w_wb;

  function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
    return (id == ID_LAST) ? ID_FIRST : id + ID_FIRST;
  endfunction

  function automatic logic valid_id(input logic [ID_WIDTH-1:0] id);
    return (id != '0) && (id <= ID_LAST);
  endfunction

  // The flush cycle is dead time. Nothing new is accepted until the buffer
  // has been emptied on the following edge.
  assign w_active = rdy && !r_flush;
  assign w_full   = (r_count == CNT_FULL);
  assign w_alloc  = w_active && valid_from_issuer && !w_full;
  assign w_commit = w_active && r_busy[r_head] && r_ready[r_head];
  assign w_wb     = w_active && valid_from_cdb && valid_id(dest_from_cdb)
                    && r_busy[dest_from_cdb];

  assign dest_to_issuer = r_tail;
  assign full_to_issuer = w_full;

  // Operand probes. Port 0 is qj and port 1 is qk. A same-cycle CDB
  // broadcast wins over the stored copy.
  logic [1:0][ID_WIDTH-1:0] w_tag;
  logic [1:0]               w_cdb_hit;
  logic [1:0]               w_entry_hit;
  logic [1:0]               w_probe_rdy;
  logic [1:0][31:0]         w_probe_val;

  assign w_tag[0] = qj_from_issuer;
  assign w_tag[1] = qk_from_issuer;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_probe
      assign w_cdb_hit[gi]   = valid_from_cdb && (w_tag[gi] != '0)
                               && (w_tag[gi] == dest_from_cdb);
      assign w_entry_hit[gi] = valid_id(w_tag[gi]) && r_busy[w_tag[gi]]
                               && r_ready[w_tag[gi]];
      assign w_probe_rdy[gi] = (w_tag[gi] == '0) || w_cdb_hit[gi] || w_entry_hit[gi];
      assign w_probe_val[gi] = (w_tag[gi] == '0) ? 32'd0 :
                               w_cdb_hit[gi]     ? value_from_cdb :
                               w_entry_hit[gi]   ? r_value[w_tag[gi]] : 32'd0;
    end
  endgenerate

  assign ready_j_to_issuer = w_probe_rdy[0];
  assign ready_k_to_issuer = w_probe_rdy[1];
  assign value_j_to_issuer = w_probe_val[0];
  assign value_k_to_issuer = w_probe_val[1];

  // The commit registers hold their value while rdy is low. They are masked
  // here so that a stalled cycle never looks like a commit. The held commit
  // then appears in the first enabled cycle.
  assign dest_to_reg_file  = rdy ? r_dest_out  : '0;
  assign rd_to_reg_file    = rdy ? r_rd_out    : 5'd0;
  assign value_to_reg_file = rdy ? r_value_out : 32'd0;
  assign reset_to_rob_bus  = rdy && r_flush;
  assign pc_to_fetcher     = rdy ? r_pc_out    : 32'd0;

  always_ff @(posedge clk) begin
    if (rst || (rdy && r_flush)) begin
      // Reset and the edge ending a flush pulse both leave the buffer empty.
      for (int i = 0; i <= ROB_SIZE; i++) begin
        r_busy[i]  <= 1'b0;
        r_ready[i] <= 1'b0;
        r_misp[i]  <= 1'b0;
        r_rd[i]    <= 5'd0;
        r_value[i] <= 32'd0;
        r_pc[i]    <= 32'd0;
      end
      r_head      <= ID_FIRST;
      r_tail      <= ID_FIRST;
      r_count     <= '0;
      r_flush     <= 1'b0;
      r_dest_out  <= '0;
      r_rd_out    <= 5'd0;
      r_value_out <= 32'd0;
      r_pc_out    <= 32'd0;
    end else if (rdy) begin
      r_dest_out  <= '0;
      r_rd_out    <= 5'd0;
      r_value_out <= 32'd0;
      r_pc_out    <= 32'd0;
      r_flush     <= 1'b0;

      if (w_wb) begin
        r_ready[dest_from_cdb] <= 1'b1;
        r_value[dest_from_cdb] <= value_from_cdb;
        r_misp[dest_from_cdb]  <= mispredict_from_cdb;
      end

      // An allocation never targets the head being committed. Such a
      // collision would need a full buffer, and a full buffer blocks
      // allocation.
      if (w_alloc) begin
        r_busy[r_tail]  <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_misp[r_tail]  <= 1'b0;
        r_rd[r_tail]    <= rd_from_issuer;
        r_value[r_tail] <= 32'd0;
        r_pc[r_tail]    <= pc_from_issuer;
        r_tail          <= next_id(r_tail);
      end

      // The commit is placed last so that a late duplicate CDB write to the
      // retiring entry cannot keep that entry alive.
      if (w_commit) begin
        r_dest_out      <= (r_rd[r_head] != 5'd0) ? r_head : '0;
        r_rd_out        <= r_rd[r_head];
        r_value_out     <= r_value[r_head];
        r_flush         <= r_misp[r_head];
        r_pc_out        <= r_misp[r_head] ? r_pc[r_head] : 32'd0;
        r_busy[r_head]  <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_misp[r_head]  <= 1'b0;
        r_rd[r_head]    <= 5'd0;
        r_value[r_head] <= 32'd0;
        r_pc[r_head]    <= 32'd0;
        r_head          <= next_id(r_head);
      end

      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_buffer.sv
// Bench for ro_buffer: directed scenarios followed by a randomized run that is
// checked against a queue-based reference model of the reorder buffer.
module tb_ro_buffer;

  localparam int RS = 16;
  localparam int IW = 5;

  logic          clk;
  logic          rst;
  logic          rdy;
  logic          valid_from_issuer;
  logic [4:0]    rd_from_issuer;
  logic [31:0]   pc_from_issuer;
  logic [IW-1:0] dest_to_issuer;
  logic          full_to_issuer;
  logic [IW-1:0] qj_from_issuer;
  logic [IW-1:0] qk_from_issuer;
  logic          ready_j_to_issuer;
  logic          ready_k_to_issuer;
  logic [31:0]   value_j_to_issuer;
  logic [31:0]   value_k_to_issuer;
  logic          valid_from_cdb;
  logic [IW-1:0] dest_from_cdb;
  logic [31:0]   value_from_cdb;
  logic          mispredict_from_cdb;
  logic [IW-1:0] dest_to_reg_file;
  logic [4:0]    rd_to_reg_file;
  logic [31:0]   value_to_reg_file;
  logic          reset_to_rob_bus;
  logic [31:0]   pc_to_fetcher;

  int checks = 0;
  int failures = 0;

  ro_buffer #(.ROB_SIZE(RS), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .valid_from_issuer(valid_from_issuer), .rd_from_issuer(rd_from_issuer),
    .pc_from_issuer(pc_from_issuer), .dest_to_issuer(dest_to_issuer),
    .full_to_issuer(full_to_issuer), .qj_from_issuer(qj_from_issuer),
    .qk_from_issuer(qk_from_issuer), .ready_j_to_issuer(ready_j_to_issuer),
    .ready_k_to_issuer(ready_k_to_issuer), .value_j_to_issuer(value_j_to_issuer),
    .value_k_to_issuer(value_k_to_issuer), .valid_from_cdb(valid_from_cdb),
    .dest_from_cdb(dest_from_cdb), .value_from_cdb(value_from_cdb),
    .mispredict_from_cdb(mispredict_from_cdb), .dest_to_reg_file(dest_to_reg_file),
    .rd_to_reg_file(rd_to_reg_file), .value_to_reg_file(value_to_reg_file),
    .reset_to_rob_bus(reset_to_rob_bus), .pc_to_fetcher(pc_to_fetcher)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the in-flight IDs are kept as a program-order queue.
  int          m_order[$];
  bit          m_busy [32];
  bit          m_rdy  [32];
  bit          m_misp [32];
  logic [4:0]  m_rd   [32];
  logic [31:0] m_val  [32];
  logic [31:0] m_pc   [32];
  int          m_tail;
  bit          m_flush;
  int          e_dest;
  logic [4:0]  e_rd;
  logic [31:0] e_val;
  logic [31:0] e_pc;

  function automatic void model_reset();
    m_order.delete();
    for (int i = 0; i < 32; i++) begin
      m_busy[i] = 0; m_rdy[i] = 0; m_misp[i] = 0;
      m_rd[i] = 0; m_val[i] = 0; m_pc[i] = 0;
    end
    m_tail = 1; m_flush = 0;
    e_dest = 0; e_rd = 0; e_val = 0; e_pc = 0;
  endfunction

  function automatic void model_edge(bit r, bit v, logic [4:0] rd, logic [31:0] pc,
                                     bit cv, int cd, logic [31:0] cval, bit cm);
    bit do_commit;
    bit do_alloc;
    int id;
    if (!r) return;
    if (m_flush) begin
      model_reset();
      return;
    end
    do_commit = (m_order.size() > 0) && m_rdy[m_order[0]];
    do_alloc  = v && (m_order.size() < RS);
    e_dest = 0; e_rd = 0; e_val = 0; e_pc = 0;
    if (do_commit) begin
      id = m_order.pop_front();
      e_dest = (m_rd[id] != 0) ? id : 0;
      e_rd = m_rd[id];
      e_val = m_val[id];
      if (m_misp[id]) begin
        m_flush = 1;
        e_pc = m_pc[id];
      end
      m_busy[id] = 0; m_rdy[id] = 0; m_misp[id] = 0;
    end
    if (cv && cd >= 1 && cd <= RS && m_busy[cd]) begin
      m_rdy[cd] = 1; m_val[cd] = cval; m_misp[cd] = cm;
    end
    if (do_alloc) begin
      m_busy[m_tail] = 1; m_rdy[m_tail] = 0; m_misp[m_tail] = 0;
      m_rd[m_tail] = rd; m_pc[m_tail] = pc;
      m_order.push_back(m_tail);
      m_tail = (m_tail == RS) ? 1 : m_tail + 1;
    end
  endfunction

  function automatic void model_probe(int tag, bit cv, int cd, logic [31:0] cval,
                                      output bit pr, output logic [31:0] pv);
    if (tag == 0) begin pr = 1; pv = 0; end
    else if (cv && cd == tag) begin pr = 1; pv = cval; end
    else if (m_busy[tag] && m_rdy[tag]) begin pr = 1; pv = m_val[tag]; end
    else begin pr = 0; pv = 0; end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1; valid_from_issuer = 0; rd_from_issuer = 0; pc_from_issuer = 0;
    qj_from_issuer = 0; qk_from_issuer = 0; valid_from_cdb = 0;
    dest_from_cdb = 0; value_from_cdb = 0; mispredict_from_cdb = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    qj_from_issuer = 0; qk_from_issuer = 3;
    #1;
    checks++; if (dest_to_issuer !== 5'd1) begin failures++; $display("FAIL reset_dest_to_issuer got=%0d exp=1", dest_to_issuer); end
    checks++; if (full_to_issuer !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full_to_issuer); end
    checks++; if (ready_j_to_issuer !== 1'b1 || value_j_to_issuer !== 32'd0) begin failures++; $display("FAIL reset_probe_j got=%0b/%h exp=1/0", ready_j_to_issuer, value_j_to_issuer); end
    checks++; if (ready_k_to_issuer !== 1'b0) begin failures++; $display("FAIL reset_probe_k got=%0b exp=0", ready_k_to_issuer); end
    checks++; if (dest_to_reg_file !== 5'd0 || rd_to_reg_file !== 5'd0 || value_to_reg_file !== 32'd0) begin failures++; $display("FAIL reset_commit got=%0d/%0d/%h exp=0/0/0", dest_to_reg_file, rd_to_reg_file, value_to_reg_file); end
    checks++; if (reset_to_rob_bus !== 1'b0 || pc_to_fetcher !== 32'd0) begin failures++; $display("FAIL reset_flush got=%0b/%h exp=0/0", reset_to_rob_bus, pc_to_fetcher); end
  endtask

  task automatic test_basic_commit();
    do_reset();
    valid_from_issuer = 1; rd_from_issuer = 5;
    #1;
    checks++; if (dest_to_issuer !== 5'd1) begin failures++; $display("FAIL basic_alloc_id got=%0d exp=1", dest_to_issuer); end
    step();
    valid_from_issuer = 0;
    valid_from_cdb = 1; dest_from_cdb = 1; value_from_cdb = 32'hDEAD;
    step();
    valid_from_cdb = 0;
    checks++; if (dest_to_reg_file !== 5'd0) begin failures++; $display("FAIL basic_early_commit got=%0d exp=0", dest_to_reg_file); end
    step();
    checks++; if (dest_to_reg_file !== 5'd1 || rd_to_reg_file !== 5'd5 || value_to_reg_file !== 32'hDEAD) begin failures++; $display("FAIL basic_commit got=%0d/%0d/%h exp=1/5/dead", dest_to_reg_file, rd_to_reg_file, value_to_reg_file); end
    step();
    qj_from_issuer = 1;
    #1;
    checks++; if (dest_to_reg_file !== 5'd0) begin failures++; $display("FAIL basic_one_cycle got=%0d exp=0", dest_to_reg_file); end
    checks++; if (ready_j_to_issuer !== 1'b0 || dest_to_issuer !== 5'd2 || full_to_issuer !== 1'b0) begin failures++; $display("FAIL basic_after got=%0b/%0d/%0b exp=0/2/0", ready_j_to_issuer, dest_to_issuer, full_to_issuer); end
  endtask

  task automatic test_in_order();
    do_reset();
    valid_from_issuer = 1;
    for (int i = 1; i <= 3; i++) begin
      rd_from_issuer = 5'(i);
      step();
    end
    valid_from_issuer = 0;
    valid_from_cdb = 1;
    for (int i = 3; i >= 1; i--) begin
      dest_from_cdb = IW'(i); value_from_cdb = 32'(i * 32'h11);
      step();
      checks++; if (dest_to_reg_file !== 5'd0) begin failures++; $display("FAIL order_no_early id=%0d got=%0d exp=0", i, dest_to_reg_file); end
    end
    valid_from_cdb = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (dest_to_reg_file !== 5'(i) || value_to_reg_file !== 32'(i * 32'h11)) begin failures++; $display("FAIL order_commit got=%0d/%h exp=%0d/%h", dest_to_reg_file, value_to_reg_file, i, i * 32'h11); end
    end
    step();
    checks++; if (dest_to_reg_file !== 5'd0) begin failures++; $display("FAIL order_drain got=%0d exp=0", dest_to_reg_file); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    valid_from_issuer = 1;
    for (int i = 1; i <= RS; i++) begin
      rd_from_issuer = 5'(i);
      #1;
      checks++; if (dest_to_issuer !== IW'(i) || full_to_issuer !== 1'b0) begin failures++; $display("FAIL fill_id got=%0d/%0b exp=%0d/0", dest_to_issuer, full_to_issuer, i); end
      step();
    end
    checks++; if (full_to_issuer !== 1'b1 || dest_to_issuer !== 5'd1) begin failures++; $display("FAIL fill_full got=%0b/%0d exp=1/1", full_to_issuer, dest_to_issuer); end
    rd_from_issuer = 7;
    step();
    valid_from_cdb = 1; dest_from_cdb = 1; value_from_cdb = 32'hAA;
    step();
    valid_from_cdb = 0;
    checks++; if (full_to_issuer !== 1'b1) begin failures++; $display("FAIL full_hold got=%0b exp=1", full_to_issuer); end
    step();
    checks++; if (dest_to_reg_file !== 5'd1 || rd_to_reg_file !== 5'd1 || value_to_reg_file !== 32'hAA) begin failures++; $display("FAIL full_commit got=%0d/%0d/%h exp=1/1/aa", dest_to_reg_file, rd_to_reg_file, value_to_reg_file); end
    checks++; if (dest_to_issuer !== 5'd1 || full_to_issuer !== 1'b0) begin failures++; $display("FAIL full_no_alloc got=%0d/%0b exp=1/0", dest_to_issuer, full_to_issuer); end
    step();
    valid_from_issuer = 0;
    checks++; if (dest_to_issuer !== 5'd2 || full_to_issuer !== 1'b1) begin failures++; $display("FAIL wrap_alloc got=%0d/%0b exp=2/1", dest_to_issuer, full_to_issuer); end
  endtask

  task automatic test_mispredict();
    do_reset();
    valid_from_issuer = 1;
    rd_from_issuer = 1; pc_from_issuer = 32'h0;    step();
    rd_from_issuer = 4; pc_from_issuer = 32'h1000; step();
    rd_from_issuer = 6; pc_from_issuer = 32'h2000; step();
    valid_from_issuer = 0;
    valid_from_cdb = 1;
    dest_from_cdb = 3; value_from_cdb = 32'h33; mispredict_from_cdb = 0; step();
    dest_from_cdb = 2; value_from_cdb = 32'h22; mispredict_from_cdb = 1; step();
    dest_from_cdb = 1; value_from_cdb = 32'h11; mispredict_from_cdb = 0; step();
    valid_from_cdb = 0;
    step();
    checks++; if (dest_to_reg_file !== 5'd1 || reset_to_rob_bus !== 1'b0) begin failures++; $display("FAIL misp_first got=%0d/%0b exp=1/0", dest_to_reg_file, reset_to_rob_bus); end
    step();
    checks++; if (dest_to_reg_file !== 5'd2 || rd_to_reg_file !== 5'd4 || value_to_reg_file !== 32'h22) begin failures++; $display("FAIL misp_branch got=%0d/%0d/%h exp=2/4/22", dest_to_reg_file, rd_to_reg_file, value_to_reg_file); end
    checks++; if (reset_to_rob_bus !== 1'b1 || pc_to_fetcher !== 32'h1000) begin failures++; $display("FAIL misp_flush got=%0b/%h exp=1/1000", reset_to_rob_bus, pc_to_fetcher); end
    valid_from_issuer = 1; rd_from_issuer = 9;
    step();
    qj_from_issuer = 3;
    #1;
    checks++; if (reset_to_rob_bus !== 1'b0 || dest_to_reg_file !== 5'd0) begin failures++; $display("FAIL misp_pulse_end got=%0b/%0d exp=0/0", reset_to_rob_bus, dest_to_reg_file); end
    checks++; if (dest_to_issuer !== 5'd1 || full_to_issuer !== 1'b0 || ready_j_to_issuer !== 1'b0) begin failures++; $display("FAIL misp_empty got=%0d/%0b/%0b exp=1/0/0", dest_to_issuer, full_to_issuer, ready_j_to_issuer); end
    step();
    valid_from_issuer = 0;
    checks++; if (dest_to_issuer !== 5'd2 || dest_to_reg_file !== 5'd0) begin failures++; $display("FAIL misp_realloc got=%0d/%0d exp=2/0", dest_to_issuer, dest_to_reg_file); end
    step();
    checks++; if (dest_to_reg_file !== 5'd0) begin failures++; $display("FAIL misp_young_commit got=%0d exp=0", dest_to_reg_file); end
  endtask

  task automatic test_probe_forward();
    do_reset();
    valid_from_issuer = 1;
    for (int i = 0; i < 4; i++) step();
    valid_from_issuer = 0;
    valid_from_cdb = 1; dest_from_cdb = 4; value_from_cdb = 7;
    qj_from_issuer = 4; qk_from_issuer = 0;
    #1;
    checks++; if (ready_j_to_issuer !== 1'b1 || value_j_to_issuer !== 32'd7) begin failures++; $display("FAIL probe_fwd got=%0b/%h exp=1/7", ready_j_to_issuer, value_j_to_issuer); end
    checks++; if (ready_k_to_issuer !== 1'b1 || value_k_to_issuer !== 32'd0) begin failures++; $display("FAIL probe_zero got=%0b/%h exp=1/0", ready_k_to_issuer, value_k_to_issuer); end
    qk_from_issuer = 3;
    #1;
    checks++; if (ready_k_to_issuer !== 1'b0 || value_k_to_issuer !== 32'd0) begin failures++; $display("FAIL probe_pending got=%0b/%h exp=0/0", ready_k_to_issuer, value_k_to_issuer); end
    step();
    valid_from_cdb = 0;
    #1;
    checks++; if (ready_j_to_issuer !== 1'b1 || value_j_to_issuer !== 32'd7) begin failures++; $display("FAIL probe_stored got=%0b/%h exp=1/7", ready_j_to_issuer, value_j_to_issuer); end
  endtask

  task automatic test_rd_zero();
    do_reset();
    valid_from_issuer = 1;
    rd_from_issuer = 0; step();
    rd_from_issuer = 3; step();
    valid_from_issuer = 0;
    valid_from_cdb = 1;
    dest_from_cdb = 1; value_from_cdb = 32'h55; step();
    dest_from_cdb = 2; value_from_cdb = 32'h66; step();
    valid_from_cdb = 0;
    checks++; if (dest_to_reg_file !== 5'd0) begin failures++; $display("FAIL rd0_commit got=%0d exp=0", dest_to_reg_file); end
    step();
    checks++; if (dest_to_reg_file !== 5'd2 || rd_to_reg_file !== 5'd3 || value_to_reg_file !== 32'h66) begin failures++; $display("FAIL rd0_next got=%0d/%0d/%h exp=2/3/66", dest_to_reg_file, rd_to_reg_file, value_to_reg_file); end
  endtask

  task automatic test_rdy_stall();
    do_reset();
    valid_from_issuer = 1; rd_from_issuer = 8; step();
    valid_from_issuer = 0;
    valid_from_cdb = 1; dest_from_cdb = 1; value_from_cdb = 32'h77; step();
    valid_from_cdb = 0;
    rdy = 0; valid_from_issuer = 1; rd_from_issuer = 2;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (dest_to_reg_file !== 5'd0 || dest_to_issuer !== 5'd2) begin failures++; $display("FAIL stall_frozen got=%0d/%0d exp=0/2", dest_to_reg_file, dest_to_issuer); end
    end
    rdy = 1; valid_from_issuer = 0;
    step();
    checks++; if (dest_to_reg_file !== 5'd1 || value_to_reg_file !== 32'h77) begin failures++; $display("FAIL stall_resume got=%0d/%h exp=1/77", dest_to_reg_file, value_to_reg_file); end
  endtask

  task automatic test_random();
    bit r, v, cv, cm, pr;
    logic [4:0] rd;
    logic [31:0] pc, cval, pv;
    int cd, qj, qk;
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 9) < 6);
      rd = 5'($urandom); pc = $urandom; cval = $urandom;
      cv = ($urandom_range(0, 9) < 5);
      cm = ($urandom_range(0, 19) == 0);
      if (m_order.size() > 0 && $urandom_range(0, 3) != 0) cd = m_order[$urandom_range(0, m_order.size() - 1)];
      else cd = $urandom_range(0, 31);
      if (m_order.size() > 0 && $urandom_range(0, 1) != 0) qj = m_order[$urandom_range(0, m_order.size() - 1)];
      else qj = (cv && $urandom_range(0, 1) != 0) ? cd : $urandom_range(0, 17);
      qk = $urandom_range(0, 17);
      rdy = r; valid_from_issuer = v; rd_from_issuer = rd; pc_from_issuer = pc;
      valid_from_cdb = cv; dest_from_cdb = IW'(cd); value_from_cdb = cval;
      mispredict_from_cdb = cm; qj_from_issuer = IW'(qj); qk_from_issuer = IW'(qk);
      #1;
      checks++; if (dest_to_issuer !== IW'(m_tail) || full_to_issuer !== (m_order.size() == RS)) begin failures++; $display("FAIL rand_alloc cyc=%0d got=%0d/%0b exp=%0d/%0b", n, dest_to_issuer, full_to_issuer, m_tail, m_order.size() == RS); end
      model_probe(qj, cv, cd, cval, pr, pv);
      checks++; if (ready_j_to_issuer !== pr || value_j_to_issuer !== pv) begin failures++; $display("FAIL rand_probe_j cyc=%0d got=%0b/%h exp=%0b/%h", n, ready_j_to_issuer, value_j_to_issuer, pr, pv); end
      model_probe(qk, cv, cd, cval, pr, pv);
      checks++; if (ready_k_to_issuer !== pr || value_k_to_issuer !== pv) begin failures++; $display("FAIL rand_probe_k cyc=%0d got=%0b/%h exp=%0b/%h", n, ready_k_to_issuer, value_k_to_issuer, pr, pv); end
      checks++; if (dest_to_reg_file !== (r ? IW'(e_dest) : IW'(0)) || rd_to_reg_file !== (r ? e_rd : 5'd0) || value_to_reg_file !== (r ? e_val : 32'd0)) begin failures++; $display("FAIL rand_commit cyc=%0d got=%0d/%0d/%h exp=%0d/%0d/%h", n, dest_to_reg_file, rd_to_reg_file, value_to_reg_file, r ? e_dest : 0, r ? e_rd : 5'd0, r ? e_val : 32'd0); end
      checks++; if (reset_to_rob_bus !== (r && m_flush) || pc_to_fetcher !== (r ? e_pc : 32'd0)) begin failures++; $display("FAIL rand_flush cyc=%0d got=%0b/%h exp=%0b/%h", n, reset_to_rob_bus, pc_to_fetcher, r && m_flush, r ? e_pc : 32'd0); end
      @(posedge clk);
      model_edge(r, v, rd, pc, cv, cd, cval, cm);
      #1;
    end
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_basic_commit();
    test_in_order();
    test_full_wrap();
    test_mispredict();
    test_probe_forward();
    test_rd_zero();
    test_rdy_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ro_buffer.md
# ro_buffer

Reorder buffer for the out-of-order core: a circular queue of in-flight instructions, allocated in program order by the issuer, completed out of order from the common data bus, and retired in order into the register file. It is the commit-side driver of the register file's `dest/rd/value` port and the sole source of the pipeline-wide flush (`rob_bus` reset) on branch misprediction. Entry IDs are 1..`ROB_SIZE`; ID 0 means "no entry / value ready" everywhere in the core.

## Interface
- `ROB_SIZE`, 16, number of entries (IDs 1..ROB_SIZE)
- `ID_WIDTH`, 5, width of an entry ID; must satisfy 2^ID_WIDTH > ROB_SIZE
- `clk` in 1: single clock, all state on posedge
- `rst` in 1: reset, synchronous, active-high
- `rdy` in 1: global enable; low freezes all state and forces commit outputs to "no commit"
- `valid_from_issuer` in 1: allocate one entry this cycle
- `rd_from_issuer` in 5: destination architectural register (0 = none)
- `pc_from_issuer` in 32: recovery PC for a mispredicted branch
- `dest_to_issuer` out ID_WIDTH: ID that an allocation this cycle receives (tail)
- `full_to_issuer` out 1: no free entry; allocation ignored
- `qj_from_issuer`, `qk_from_issuer` in ID_WIDTH: operand tags to probe
- `ready_j_to_issuer`, `ready_k_to_issuer` out 1: tagged value available
- `value_j_to_issuer`, `value_k_to_issuer` out 32: that value (0 when not ready)
- `valid_from_cdb` in 1, `dest_from_cdb` in ID_WIDTH, `value_from_cdb` in 32: result broadcast
- `mispredict_from_cdb` in 1: broadcast entry is a mispredicted branch
- `dest_to_reg_file` out ID_WIDTH, `rd_to_reg_file` out 5, `value_to_reg_file` out 32: commit port (dest 0 = no commit)
- `reset_to_rob_bus` out 1: one-cycle flush pulse
- `pc_to_fetcher` out 32: redirect PC, meaningful only with flush pulse

## Operation
- Per-entry state: busy, ready, mispredict, rd[4:0], value[31:0], pc[31:0]. Pointers head, tail (IDs), count.
- Allocate: `valid_from_issuer && !full_to_issuer && !reset_to_rob_bus` → entry[tail] busy=1, ready=0, mispredict=0, rd, pc stored; tail advances; wrap ROB_SIZE → 1.
- Writeback: `valid_from_cdb` with nonzero dest of a busy entry → ready=1, value, mispredict latched. CDB to a non-busy entry or dest 0 ignored.
- Commit (max one per cycle): head busy and ready → entry cleared, head advances with wrap, count decrements. Registered outputs next cycle: dest=head ID, rd, value. If committed rd==0, dest_to_reg_file=0 (x0 never written). Non-commit cycles drive dest 0, rd 0, value 0.
- Mispredict commit: commit as above (rd written if nonzero), plus `reset_to_rob_bus`=1 and `pc_to_fetcher`=stored pc in the same output cycle; on that edge all entries clear, head=tail=1, count=0.
- While `reset_to_rob_bus` is high: allocation, writeback and commit all ignored.
- Probe (combinational): tag 0 → ready 1, value 0; same-cycle CDB match on tag → ready 1, CDB value (forward); else busy and ready entry → ready 1, stored value; else ready 0, value 0.
- `full_to_issuer` = (count == ROB_SIZE), from current count; a commit in the same cycle does not free the slot for allocation.
- Simultaneous allocate + commit: count unchanged, both pointers advance.
- `rst`: all entries cleared, head=tail=1, count=0.

## Timing
- Reset values: dest_to_issuer=1, full=0, ready_j/k=1 only if probe tag 0 (combinational), commit outputs 0, reset_to_rob_bus=0, pc_to_fetcher=0.
- `dest_to_issuer`, `full_to_issuer`, probe outputs: combinational from current state/inputs.
- CDB write at edge t → earliest commit decision at edge t+1 → commit outputs visible after edge t+1 (2-cycle CDB-to-regfile).
- Mispredict branch committing at edge t: flush pulse high for exactly cycle after edge t; state empty after edge t+1; issuer may allocate ID 1 in the cycle after the pulse.
- `rdy` low: no state change; commit outputs and flush 0 for that cycle; a pending commit occurs on the first `rdy`-high edge.

## Test plan
- Reset, then allocate rd=5 (ID 1), CDB dest=1 value=0xDEAD → two edges later dest_to_reg_file=1, rd=5, value=0xDEAD for one cycle; count back to 0.
- Allocate IDs 1,2,3; CDB completes 3, then 2, then 1 → commits appear as IDs 1,2,3 on consecutive cycles, never out of order.
- Fill 16 entries → full=1, 17th valid ignored; commit head while issuer holds valid → no allocation that cycle, allocation of ID 1 (wrapped) next cycle.
- Branch at ID 2 with pc 0x1000, CDB mispredict=1, younger ID 3 already ready → ID 2 commits with reset_to_rob_bus=1, pc_to_fetcher=0x1000; ID 3 never commits; dest_to_issuer=1 afterward.
- Probe qj=4 while CDB broadcasts dest=4 value=7 → ready_j=1, value_j=7 same cycle; qk=0 → ready_k=1, value_k=0.
- Allocate rd=0, complete it → commit cycle shows dest_to_reg_file=0; head advances.
